// File: rtl/sl_wb_trace_buf.sv
// sl_wb_trace_buf
// ---------------
// Passive Wishbone (classic) bus monitor. The block watches a Wishbone
// master/slave pair and records one trace entry per completed transfer:
// direction, address, data and the number of cycles the slave held the
// master waiting. Records go into a first-word-fall-through FIFO that a
// trace consumer drains through a valid/ready handshake. Records that
// arrive while the FIFO is full are dropped and counted.
//
// Optional feature (compile-time macro SL_WB_TRACE_TIMEOUT_EN):
//   A watchdog that emits a timeout record (trc_to=1, lat=TIMEOUT) when a
//   slave has not acknowledged within TIMEOUT cycles. It raises the sticky
//   'timeout' flag and parks the monitor in HUNG until the master gives
//   up the cycle. Without the macro, HUNG and the watchdog are absent and
//   timeout/trc_to read as 0.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   wb_cyc .. wb_ack  : observed Wishbone control signals (inputs only)
//   wb_adr            : observed address
//   wb_dat_o          : observed master write data
//   wb_dat_i          : observed slave read data
//   trc_valid/ready   : trace output handshake (pop on valid & ready)
//   trc_we/to/adr/dat/lat : head-of-FIFO trace record
//   trc_level         : FIFO occupancy, 0..DEPTH
//   ovf_cnt           : saturating count of dropped records
//   timeout           : sticky watchdog flag (0 without the macro)

module sl_wb_trace_buf #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int LAT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_cyc,
  input  logic                     wb_stb,
  input  logic                     wb_we,
  input  logic                     wb_ack,
  input  logic [ADDR_W-1:0]        wb_adr,
  input  logic [DATA_W-1:0]        wb_dat_o,
  input  logic [DATA_W-1:0]        wb_dat_i,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic                     trc_we,
  output logic                     trc_to,
  output logic [ADDR_W-1:0]        trc_adr,
  output logic [DATA_W-1:0]        trc_dat,
  output logic [LAT_W-1:0]         trc_lat,
  output logic [$clog2(DEPTH):0]   trc_level,
  output logic [15:0]              ovf_cnt,
  output logic                     timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = 1 + ADDR_W + DATA_W + LAT_W;

  localparam logic [LAT_W-1:0] LAT_MAX   = '1;
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

`ifdef SL_WB_TRACE_TIMEOUT_EN
  localparam logic [LAT_W-1:0] TIMEOUT_LAT = LAT_W'(TIMEOUT);
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1
`ifdef SL_WB_TRACE_TIMEOUT_EN
    ,S_HUNG    = 2'd2
`endif
  } state_e;

  // ---------------------------------------------------------------------
  // Monitor state
  // ---------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   dat_q, dat_d;

  logic                push_req;
  logic [REC_W-1:0]    push_rec;
  logic                bus_req;

`ifdef SL_WB_TRACE_TIMEOUT_EN
  logic                push_to;
  logic                timeout_q, timeout_d;
`endif

  assign bus_req = wb_cyc & wb_stb;

  // Next-state logic for the bus monitor. push_req/push_rec describe the
  // record offered to the FIFO this cycle; the FIFO decides whether it fits.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    adr_d    = adr_q;
    we_d     = we_q;
    dat_d    = dat_q;
    push_req = 1'b0;
    push_rec = '0;
`ifdef SL_WB_TRACE_TIMEOUT_EN
    push_to   = 1'b0;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus_req) begin
          if (wb_ack) begin
            // Zero-wait transfer: record straight from the bus.
            push_req = 1'b1;
            push_rec = {wb_we, wb_adr, (wb_we ? wb_dat_o : wb_dat_i),
                        {LAT_W{1'b0}}};
          end else begin
            // This cycle already counts as the first wait cycle.
            adr_d   = wb_adr;
            we_d    = wb_we;
            dat_d   = wb_dat_o;
            lat_d   = LAT_W'(1);
            state_d = S_WAIT_ACK;
          end
        end
      end

      S_WAIT_ACK: begin
        if (!bus_req) begin
          // Master abandoned the cycle: nothing is recorded.
          state_d = S_IDLE;
        end else if (wb_ack) begin
          push_req = 1'b1;
          push_rec = {we_q, adr_q, (we_q ? dat_q : wb_dat_i), lat_q};
          state_d  = S_IDLE;
        end
`ifdef SL_WB_TRACE_TIMEOUT_EN
        else if (lat_q == TIMEOUT_LAT) begin
          // Watchdog fired; read data never arrived, so reads record 0.
          push_req  = 1'b1;
          push_to   = 1'b1;
          push_rec  = {we_q, adr_q, (we_q ? dat_q : {DATA_W{1'b0}}),
                       TIMEOUT_LAT};
          timeout_d = 1'b1;
          state_d   = S_HUNG;
        end
`endif
        else if (lat_q != LAT_MAX) begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

`ifdef SL_WB_TRACE_TIMEOUT_EN
      S_HUNG: begin
        // A late ack is ignored; wait for the master to release the bus.
        if (!bus_req) begin
          state_d = S_IDLE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
    end
  end

`ifdef SL_WB_TRACE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Trace FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  logic [REC_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [15:0]         ovf_q, ovf_d;

  logic                full;
  logic                pop;
  logic                do_push;

  assign full    = (level_q == LVL_FULL);
  assign pop     = trc_valid & trc_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_req & (~full | pop);

  // Pointer, occupancy and overflow bookkeeping. Pointers are PTR_W bits
  // wide, so with a power-of-two DEPTH they wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (do_push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!do_push && pop) begin
      level_d = level_q - LVL_W'(1);
    end

    if (push_req && !do_push && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: trc_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_rec;
    end
  end

  assign {trc_we, trc_adr, trc_dat, trc_lat} = mem_q[rd_ptr_q];

`ifdef SL_WB_TRACE_TIMEOUT_EN
  logic to_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (do_push) begin
      to_mem_q[wr_ptr_q] <= push_to;
    end
  end

  assign trc_to = to_mem_q[rd_ptr_q];
`else
  assign trc_to = 1'b0;
`endif

  assign trc_valid = (level_q != '0);
  assign trc_level = level_q;
  assign ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_sl_wb_trace_buf.sv
// Testbench for sl_wb_trace_buf. Expected trace records are pushed to a
// scoreboard queue as each bus transfer is driven, and compared in order as
// the DUT presents them on the trace port.

module tb_sl_wb_trace_buf;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int LAT_W   = 8;
  localparam int TIMEOUT = 5;

  typedef struct packed {
    logic        we;
    logic        to;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [7:0]  lat;
  } rec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_cyc, wb_stb, wb_we, wb_ack;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_dat_o, wb_dat_i;
  logic              trc_valid, trc_ready, trc_we, trc_to;
  logic [ADDR_W-1:0] trc_adr;
  logic [DATA_W-1:0] trc_dat;
  logic [LAT_W-1:0]  trc_lat;
  logic [4:0]        trc_level;
  logic [15:0]       ovf_cnt;
  logic              timeout;

  int   tests_run    = 0;
  int   tests_failed = 0;
  rec_t exp_q[$];
  int   exp_ovf      = 0;

  always #5 clk = ~clk;

  sl_wb_trace_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LAT_W  (LAT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_ack   (wb_ack),
    .wb_adr   (wb_adr),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .trc_valid(trc_valid),
    .trc_ready(trc_ready),
    .trc_we   (trc_we),
    .trc_to   (trc_to),
    .trc_adr  (trc_adr),
    .trc_dat  (trc_dat),
    .trc_lat  (trc_lat),
    .trc_level(trc_level),
    .ovf_cnt  (ovf_cnt),
    .timeout  (timeout)
  );

  // Scoreboard push: models FIFO capacity (bench keeps trc_ready low while
  // transfers run, except where a test pops explicitly beforehand).
  task automatic expect_rec(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input int waits);
    rec_t e;
    e.we  = we;
    e.to  = 1'b0;
    e.adr = adr;
    e.dat = dat;
    e.lat = (waits > 255) ? 8'd255 : 8'(waits);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_ovf++;
  endtask

  // Drive one Wishbone transfer starting at a negedge; the slave acks after
  // 'waits' cycles. Returns at the negedge after the ack cycle.
  task automatic bus_xfer(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input int waits,
                          input bit keep);
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_adr   = adr;
    wb_dat_o = we ? dat : 32'hDEAD_BEEF;
    wb_dat_i = 32'h0BAD_0BAD;
    wb_ack   = 1'b0;
    for (int i = 0; i < waits; i++) @(negedge clk);
    wb_ack = 1'b1;
    if (!we) wb_dat_i = dat;
    expect_rec(we, adr, dat, waits);
    @(negedge clk);
    wb_ack = 1'b0;
    if (!keep) begin
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
    end
  endtask

  // Pop everything the DUT holds and compare with the scoreboard in order.
  task automatic drain(input string tag);
    rec_t e, got;
    bit   done = 0;
    trc_ready = 1'b1;
    for (int c = 0; c < 4 * DEPTH && !done; c++) begin
      if (trc_valid) begin
        got = {trc_we, trc_to, trc_adr, trc_dat, trc_lat};
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL %s_extra: got record %h, required none", tag, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            tests_failed++;
            $display("[TB] FAIL %s_rec: got %h, required %h", tag, got, e);
          end
        end
      end else if (exp_q.size() == 0) begin
        done = 1;
      end
      if (!done) @(negedge clk);
    end
    trc_ready = 1'b0;
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("[TB] FAIL %s_drain: %0d records missing, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_ack = 0;
    wb_adr = '0; wb_dat_o = '0; wb_dat_i = '0; trc_ready = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (trc_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rst_valid: got %b, required 0", trc_valid);
    end
    tests_run++;
    if (trc_level !== 5'd0) begin
      tests_failed++; $display("[TB] FAIL rst_level: got %0d, required 0", trc_level);
    end
    tests_run++;
    if (ovf_cnt !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL rst_ovf: got %0d, required 0", ovf_cnt);
    end
    tests_run++;
    if ({timeout, trc_to} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL rst_timeout: got %b, required 00", {timeout, trc_to});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait_read();
    bus_xfer(1'b0, 32'h10, 32'hA5, 0, 0);
    tests_run++;
    if (trc_level !== 5'd1) begin
      tests_failed++; $display("[TB] FAIL zw_level: got %0d, required 1", trc_level);
    end
    drain("zw_read");
  endtask

  task automatic test_write_wait();
    bus_xfer(1'b1, 32'h20, 32'h1234, 3, 0);
    tests_run++;
    if (trc_level !== 5'd1) begin
      tests_failed++; $display("[TB] FAIL ww_level: got %0d, required 1", trc_level);
    end
    drain("wr_wait");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 17; i++)
      bus_xfer(1'b1, 32'h100 + 32'(i * 4), 32'h5000 + 32'(i), 0, (i != 16));
    tests_run++;
    if (trc_level !== 5'd16) begin
      tests_failed++; $display("[TB] FAIL b2b_level: got %0d, required 16", trc_level);
    end
    tests_run++;
    if (ovf_cnt !== 16'(exp_ovf)) begin
      tests_failed++; $display("[TB] FAIL b2b_ovf: got %0d, required %0d", ovf_cnt, exp_ovf);
    end
    drain("b2b");
  endtask

  task automatic test_full_pop();
    rec_t e, got;
    for (int i = 0; i < 16; i++)
      bus_xfer(1'b0, 32'h200 + 32'(i), 32'h6000 + 32'(i), 0, 1);
    // 17th ack coincides with a pop of the head entry.
    trc_ready = 1'b1;
    got = {trc_we, trc_to, trc_adr, trc_dat, trc_lat};
    e = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++; $display("[TB] FAIL fp_head: got %h, required %h", got, e);
    end
    bus_xfer(1'b0, 32'h2FF, 32'h6FFF, 0, 0);
    trc_ready = 1'b0;
    tests_run++;
    if (trc_level !== 5'd16) begin
      tests_failed++; $display("[TB] FAIL fp_level: got %0d, required 16", trc_level);
    end
    tests_run++;
    if (ovf_cnt !== 16'(exp_ovf)) begin
      tests_failed++; $display("[TB] FAIL fp_ovf: got %0d, required %0d", ovf_cnt, exp_ovf);
    end
    drain("full_pop");
  endtask

  task automatic test_abort();
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h30; wb_dat_o = 32'h33; wb_ack = 0;
    repeat (2) @(negedge clk);
    // Drop the cycle; a stray ack with cyc low must not be recorded.
    wb_cyc = 0; wb_stb = 0; wb_ack = 1;
    repeat (2) @(negedge clk);
    wb_ack = 0;
    @(negedge clk);
    tests_run++;
    if (trc_level !== 5'd0) begin
      tests_failed++; $display("[TB] FAIL abort_level: got %0d, required 0", trc_level);
    end
    bus_xfer(1'b0, 32'h40, 32'h77, 1, 0);
    drain("abort_next");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      bus_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 4), 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    tests_run++;
    if (trc_level !== 5'(exp_q.size())) begin
      tests_failed++; $display("[TB] FAIL rnd_level: got %0d, required %0d", trc_level, exp_q.size());
    end
    drain("random");
  endtask

`ifdef SL_WB_TRACE_TIMEOUT_EN
  task automatic test_timeout();
    rec_t e;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h70; wb_ack = 0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (trc_level !== 5'd0) begin
      tests_failed++; $display("[TB] FAIL to_early: got %0d, required 0", trc_level);
    end
    @(negedge clk);
    e = '{we: 1'b0, to: 1'b1, adr: 32'h70, dat: 32'h0, lat: 8'd5};
    exp_q.push_back(e);
    tests_run++;
    if (timeout !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL to_flag: got %b, required 1", timeout);
    end
    wb_ack = 1; wb_dat_i = 32'h1111;
    repeat (2) @(negedge clk);
    wb_ack = 0; wb_cyc = 0; wb_stb = 0;
    @(negedge clk);
    tests_run++;
    if (trc_level !== 5'd1) begin
      tests_failed++; $display("[TB] FAIL to_late_ack: got %0d, required 1", trc_level);
    end
    drain("timeout");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ovf = 0;
    tests_run++;
    if (timeout !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL to_clear: got %b, required 0", timeout);
    end
  endtask
`else
  task automatic test_lat_saturate();
    bus_xfer(1'b1, 32'h60, 32'hCAFE, 300, 0);
    drain("lat_sat");
    tests_run++;
    if ({timeout, trc_to} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL sat_timeout: got %b, required 00", {timeout, trc_to});
    end
  endtask
`endif

  task automatic test_reset_mid();
    bus_xfer(1'b1, 32'h80, 32'h88, 0, 0);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h90; wb_ack = 0;
    repeat (2) @(negedge clk);
    wb_ack = 1;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({trc_valid, trc_level} !== 6'd0) begin
      tests_failed++; $display("[TB] FAIL rmid_async: got valid=%b level=%0d, required 0/0", trc_valid, trc_level);
    end
    exp_q.delete();
    exp_ovf = 0;
    @(negedge clk);
    wb_cyc = 0; wb_stb = 0; wb_ack = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({trc_level, ovf_cnt} !== 21'd0) begin
      tests_failed++; $display("[TB] FAIL rmid_state: got level=%0d ovf=%0d, required 0/0", trc_level, ovf_cnt);
    end
    bus_xfer(1'b0, 32'h94, 32'h99, 2, 0);
    drain("rmid_next");
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_back_to_back();
    test_full_pop();
    test_abort();
    test_random();
`ifdef SL_WB_TRACE_TIMEOUT_EN
    test_timeout();
`else
    test_lat_saturate();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sl_wb_trace_buf.md
SL_WB_TRACE_BUF -- requirements
Module: sl_wb_trace_buf

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, Wishbone address width.
REQ-002 SHALL have parameter DATA_W, default 32, Wishbone data width.
REQ-003 SHALL have parameter DEPTH, default 16, trace FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter LAT_W, default 8, latency field width.
REQ-005 SHALL have parameter TIMEOUT, default 200, watchdog limit in cycles (< 2^LAT_W).
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-high reset.
REQ-007 SHALL have ports: wb_cyc, wb_stb, wb_we, wb_ack in 1; wb_adr in ADDR_W; wb_dat_o in DATA_W (master write data); wb_dat_i in DATA_W (slave read data). All are observed only, never driven.
REQ-008 SHALL have ports: trc_valid out 1; trc_ready in 1; trc_we out 1; trc_to out 1 (timeout record); trc_adr out ADDR_W; trc_dat out DATA_W; trc_lat out LAT_W.
REQ-009 SHALL have ports: trc_level out $clog2(DEPTH)+1 (occupancy); ovf_cnt out 16 (dropped records); timeout out 1 (sticky).

Function
REQ-010 SHALL implement FSM IDLE, WAIT_ACK, HUNG; transitions are evaluated on rising clk.
REQ-011 In IDLE, when cyc&stb&ack is high, SHALL push a record with lat=0 and remain in IDLE.
REQ-012 In IDLE, when cyc&stb is high and ack is low, SHALL latch adr, we, dat_o, clear the latency counter to 1, and go to WAIT_ACK.
REQ-013 In WAIT_ACK, each cycle without ack SHALL increment the latency counter, saturating at 2^LAT_W-1.
REQ-014 In WAIT_ACK, on ack with cyc&stb high, SHALL push {we, adr, dat, lat} and go to IDLE. dat is wb_dat_i sampled at ack for reads, or the latched dat_o for writes.
REQ-015 In WAIT_ACK, if cyc or stb drops before ack, SHALL discard the transaction without pushing and go to IDLE.
REQ-016 SHALL return to IDLE after a push and require stb to be sampled again, so back-to-back transfers each produce one record.
REQ-017 The FIFO SHALL be first-word-fall-through: trc_valid = level!=0, and outputs show the head entry.
REQ-018 A pop SHALL occur when trc_valid&trc_ready.
REQ-019 A push into a full FIFO SHALL drop the record and increment ovf_cnt, saturating at 0xFFFF.
REQ-020 A simultaneous push and pop when full SHALL accept the push with no overflow.
REQ-021 A simultaneous push and pop when empty SHALL write the new entry; trc_valid goes high next cycle.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH. trc_level SHALL be exact, including the value DEPTH.

Reset
REQ-023 rst SHALL asynchronously force: FSM=IDLE, pointers=0, trc_level=0, trc_valid=0, ovf_cnt=0, timeout=0, latency=0, latched fields=0.
REQ-024 rst asserted mid-transaction SHALL abandon the transaction with no record produced. Monitoring restarts at the first cyc&stb after rst deassertion.

Configuration
REQ-025 Macro SL_WB_TRACE_TIMEOUT_EN compiled in: in WAIT_ACK, when the latency counter reaches TIMEOUT without ack, the block SHALL push a record with trc_to=1 and lat=TIMEOUT, set timeout (sticky until rst), and go to HUNG.
REQ-026 With the macro compiled in: HUNG SHALL ignore ack and return to IDLE only when cyc or stb is low.
REQ-027 Macro absent: HUNG state and watchdog SHALL not exist. timeout and trc_to SHALL be tied to 0, and the latency counter only saturates.

Verification
REQ-028 Zero-wait read: cyc/stb/ack high 1 cycle, adr=0x10, dat_i=0xA5 -> one record: we=0, adr=0x10, dat=0xA5, lat=0.
REQ-029 Write, ack after 3 wait cycles: adr=0x20, dat_o=0x1234 -> record: we=1, dat=0x1234, lat=3; trc_level=1.
REQ-030 17 back-to-back zero-wait writes with trc_ready=0, DEPTH=16 -> trc_level=16, ovf_cnt=1; then draining 16 pops yields the first 16 addresses in order.
REQ-031 Full FIFO with trc_ready=1 on the same cycle as the 17th ack -> no overflow, trc_level stays 16.
REQ-032 cyc dropped after 2 wait cycles -> no record, FSM in IDLE; the next transfer records normally.
REQ-033 With SL_WB_TRACE_TIMEOUT_EN, TIMEOUT=5, no ack -> 5 cycles after stb: record trc_to=1, lat=5, timeout=1. A late ack produces no record. rst clears timeout.
